// File: rtl/cond_logic_it.sv
// cond_logic_it: NZCV flag register, ARM condition evaluation and IT sequencing.
// Optional macro COND_PERF_CNT_EN adds exec_cnt/skip_cnt counters.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   instr_valid           instruction advances; qualifies every state update
//   Cond                  condition field, used outside an IT block
//   ALUFlags, FlagW       new flags and per-group write request
//   PCS, RegW, MemW       ungated write requests from the decoder
//   it_start              current instruction is IT
//   it_firstcond, it_mask IT operands
//   PCSrc, RegWrite,
//   MemWrite              gated write enables
//   CondEx                condition passed
//   Flags                 architectural flags, {N,Z,C,V} in [3:0]
//   it_active, it_err     IT block in progress / illegal-IT pulse
//   exec_cnt, skip_cnt    saturating counters (COND_PERF_CNT_EN only)
// FLAG_W must be >= 4 and divisible by NGRP.
module cond_logic_it #(
   parameter int FLAG_W = 4,
   parameter int NGRP   = 2
`ifdef COND_PERF_CNT_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [3:0]        Cond,
   input  logic [FLAG_W-1:0] ALUFlags,
   input  logic [NGRP-1:0]   FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              it_start,
   input  logic [3:0]        it_firstcond,
   input  logic [3:0]        it_mask,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic [FLAG_W-1:0] Flags,
   output logic              it_active,
   output logic              it_err
`ifdef COND_PERF_CNT_EN
   ,output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0]  skip_cnt
`endif
);

   localparam int GW = FLAG_W / NGRP;

   logic [7:0] itstate;
   logic [3:0] ec;
   logic       n, z, c, v;
   logic       pass;
   logic       it_bad;

   assign {n, z, c, v} = Flags[3:0];

   assign it_active = |itstate[3:0];
   assign ec        = it_active ? itstate[7:4] : Cond;

   always_comb begin
      pass = 1'b1;
      case (ec)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b0010: pass = c;
         4'b0011: pass = ~c;
         4'b0100: pass = n;
         4'b0101: pass = ~n;
         4'b0110: pass = v;
         4'b0111: pass = ~v;
         4'b1000: pass = c & ~z;
         4'b1001: pass = ~c | z;
         4'b1010: pass = (n == v);
         4'b1011: pass = (n != v);
         4'b1100: pass = ~z & (n == v);
         4'b1101: pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end

   assign CondEx   = pass;
   assign PCSrc    = PCS  & CondEx & instr_valid;
   assign RegWrite = RegW & CondEx & instr_valid;
   assign MemWrite = MemW & CondEx & instr_valid;

   // Nested IT, empty mask or firstcond 1111 are rejected.
   assign it_bad = it_active
                 | (it_mask == 4'b0000)
                 | (it_firstcond == 4'b1111);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags   <= '0;
         itstate <= '0;
         it_err  <= 1'b0;
      end else begin
         it_err <= 1'b0;
         if (instr_valid) begin
            for (int g = 0; g < NGRP; g++) begin
               if (FlagW[g] && CondEx)
                  Flags[g*GW +: GW] <= ALUFlags[g*GW +: GW];
            end
            if (it_start) begin
               if (it_bad)
                  it_err <= 1'b1;
               else
                  itstate <= {it_firstcond, it_mask};
            end else if (it_active) begin
               // A taken branch or the last slot ends the block.
               if (PCSrc || (itstate[2:0] == 3'b000))
                  itstate <= '0;
               else
                  itstate[4:0] <= {itstate[3:0], 1'b0};
            end
         end
      end
   end

`ifdef COND_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exec_cnt <= '0;
         skip_cnt <= '0;
      end else if (instr_valid && !it_start) begin
         if (CondEx) begin
            if (exec_cnt != '1)
               exec_cnt <= exec_cnt + CNT_W'(1);
         end else begin
            if (skip_cnt != '1)
               skip_cnt <= skip_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cond_logic_it.sv
// tb_cond_logic_it: directed-vector bench for cond_logic_it.
// Expected values are hand-computed for FLAG_W=4, NGRP=2.
module tb_cond_logic_it;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW;
   logic       it_start;
   logic [3:0] it_firstcond;
   logic [3:0] it_mask;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;
   logic       it_active, it_err;
`ifdef COND_PERF_CNT_EN
   logic [1:0] exec_cnt, skip_cnt;
`endif

   int nvec = 0;
   int nerr = 0;
   logic [15:0] tbl;

   always #5 clk = ~clk;

   cond_logic_it #(
      .FLAG_W(4),
      .NGRP(2)
`ifdef COND_PERF_CNT_EN
      ,.CNT_W(2)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .instr_valid(instr_valid),
      .Cond(Cond),
      .ALUFlags(ALUFlags),
      .FlagW(FlagW),
      .PCS(PCS),
      .RegW(RegW),
      .MemW(MemW),
      .it_start(it_start),
      .it_firstcond(it_firstcond),
      .it_mask(it_mask),
      .PCSrc(PCSrc),
      .RegWrite(RegWrite),
      .MemWrite(MemWrite),
      .CondEx(CondEx),
      .Flags(Flags),
      .it_active(it_active),
      .it_err(it_err)
`ifdef COND_PERF_CNT_EN
      ,.exec_cnt(exec_cnt),
      .skip_cnt(skip_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      instr_valid  = 1'b0;
      Cond         = 4'he;
      ALUFlags     = 4'h0;
      FlagW        = 2'b00;
      PCS          = 1'b0;
      RegW         = 1'b0;
      MemW         = 1'b0;
      it_start     = 1'b0;
      it_firstcond = 4'h0;
      it_mask      = 4'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      reset = 1'b1;
      Cond  = 4'h0;
      #2;
      chk("rst_flags", Flags, 4'h0);
      chk("rst_active", it_active, 1'b0);
      chk("rst_err", it_err, 1'b0);
      chk("rst_condex_eq", CondEx, 1'b0);
      #1 reset = 1'b0;
      tick();

      // EQ fails with Z=0: flag write suppressed
      instr_valid = 1'b1; Cond = 4'h0;
      ALUFlags = 4'b0100; FlagW = 2'b11;
      #1 chk("eq_fail_condex", CondEx, 1'b0);
      tick();
      chk("eq_fail_flags", Flags, 4'h0);

      Cond = 4'he;
      #1 chk("al_condex", CondEx, 1'b1);
      tick();
      chk("al_flags", Flags, 4'b0100);

      FlagW = 2'b00; Cond = 4'h0;
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
      #1;
      chk("eq_regwrite", RegWrite, 1'b1);
      chk("eq_memwrite", MemWrite, 1'b1);
      chk("eq_pcsrc", PCSrc, 1'b1);
      Cond = 4'h1;
      #1 chk("ne_regwrite", RegWrite, 1'b0);
      tick();

      // instr_valid=0 gates enables and freezes state
      instr_valid = 1'b0; Cond = 4'he; RegW = 1'b1;
      PCS = 1'b0; MemW = 1'b0;
      FlagW = 2'b11; ALUFlags = 4'hf;
      #1;
      chk("nv_condex", CondEx, 1'b1);
      chk("nv_regwrite", RegWrite, 1'b0);
      tick();
      chk("nv_flags", Flags, 4'b0100);

      // group split
      instr_valid = 1'b1; RegW = 1'b0;
      ALUFlags = 4'h0; FlagW = 2'b11;
      tick();
      chk("grp_clear", Flags, 4'h0);
      FlagW = 2'b10; ALUFlags = 4'hf;
      tick();
      chk("grp_hi", Flags, 4'b1100);
      FlagW = 2'b01;
      tick();
      chk("grp_lo", Flags, 4'b1111);

      // all 16 codes with N=1 Z=0 C=1 V=0
      ALUFlags = 4'b1010; FlagW = 2'b11;
      tick();
      chk("set_1010", Flags, 4'b1010);
      instr_valid = 1'b0; FlagW = 2'b00;
      tbl = 16'hE996;
      for (int i = 0; i < 16; i++) begin
         Cond = 4'(i);
         #1 chk($sformatf("cc1010_%0d", i), CondEx, tbl[i]);
      end

      // all 16 codes with Z=1
      instr_valid = 1'b1; Cond = 4'he;
      ALUFlags = 4'b0100; FlagW = 2'b11;
      tick();
      chk("set_0100", Flags, 4'b0100);
      instr_valid = 1'b0; FlagW = 2'b00;
      tbl = 16'hE6A9;
      for (int i = 0; i < 16; i++) begin
         Cond = 4'(i);
         #1 chk($sformatf("cc0100_%0d", i), CondEx, tbl[i]);
      end
      tick();

      // ITTE EQ: EC 0000,0000,0001
      clr();
      instr_valid = 1'b1; it_start = 1'b1;
      it_firstcond = 4'h0; it_mask = 4'b0110;
      #1 chk("it_pre_active", it_active, 1'b0);
      tick();
      chk("it_active1", it_active, 1'b1);
      chk("it_err_ok", it_err, 1'b0);

      it_start = 1'b0; RegW = 1'b1;
      #1 chk("it_i1_regwrite", RegWrite, 1'b1);
      tick();
      chk("it_i1_active", it_active, 1'b1);

      // nested IT: error pulse, state frozen
      it_start = 1'b1; RegW = 1'b0;
      it_firstcond = 4'h1; it_mask = 4'b1000;
      tick();
      chk("nest_err", it_err, 1'b1);
      chk("nest_active", it_active, 1'b1);

      it_start = 1'b0; RegW = 1'b1;
      #1 chk("it_i2_regwrite", RegWrite, 1'b1);
      tick();
      chk("nest_err_pulse", it_err, 1'b0);
      chk("it_i2_active", it_active, 1'b1);

      // else slot skipped, its flag write dropped
      FlagW = 2'b11; ALUFlags = 4'h0;
      #1 chk("it_i3_regwrite", RegWrite, 1'b0);
      tick();
      chk("it_i3_active", it_active, 1'b0);
      chk("it_i3_flags", Flags, 4'b0100);

      // illegal IT forms outside a block
      RegW = 1'b0; FlagW = 2'b00;
      it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'h0;
      tick();
      chk("mask0_err", it_err, 1'b1);
      chk("mask0_active", it_active, 1'b0);
      it_firstcond = 4'hf; it_mask = 4'b1000;
      tick();
      chk("fc15_err", it_err, 1'b1);
      chk("fc15_active", it_active, 1'b0);
      clr();
      tick();
      chk("err_clear", it_err, 1'b0);

      // single-slot IT NE with Z=1
      instr_valid = 1'b1; it_start = 1'b1;
      it_firstcond = 4'h1; it_mask = 4'b1000;
      tick();
      chk("len1_active", it_active, 1'b1);
      it_start = 1'b0; RegW = 1'b1;
      #1 chk("len1_regwrite", RegWrite, 1'b0);
      tick();
      chk("len1_done", it_active, 1'b0);

      // 4-slot AL block cut short by a taken branch
      RegW = 1'b0; it_start = 1'b1;
      it_firstcond = 4'he; it_mask = 4'b0001;
      tick();
      it_start = 1'b0; RegW = 1'b1;
      #1 chk("br_i1_regwrite", RegWrite, 1'b1);
      tick();
      chk("br_i1_active", it_active, 1'b1);
      RegW = 1'b0; PCS = 1'b1;
      #1 chk("br_pcsrc", PCSrc, 1'b1);
      tick();
      chk("br_active", it_active, 1'b0);
      PCS = 1'b0; RegW = 1'b1; Cond = 4'h1;
      #1 chk("br_after_cond", RegWrite, 1'b0);
      tick();

      // async reset mid-block
      clr();
      instr_valid = 1'b1; it_start = 1'b1;
      it_firstcond = 4'he; it_mask = 4'b0001;
      tick();
      chk("rb_active", it_active, 1'b1);
      it_start = 1'b0; instr_valid = 1'b0; Cond = 4'h0;
      #2 reset = 1'b1;
      #1;
      chk("rb_active0", it_active, 1'b0);
      chk("rb_flags", Flags, 4'h0);
      chk("rb_uses_cond", CondEx, 1'b0);
      #1 reset = 1'b0;
      tick();

`ifdef COND_PERF_CNT_EN
      reset = 1'b1;
      #1;
      chk("pc_rst_exec", exec_cnt, 2'd0);
      chk("pc_rst_skip", skip_cnt, 2'd0);
      reset = 1'b0;
      clr();
      instr_valid = 1'b1; Cond = 4'he;
      repeat (5) tick();
      Cond = 4'h0;
      repeat (2) tick();
      instr_valid = 1'b0;
      chk("pc_exec_sat", exec_cnt, 2'd3);
      chk("pc_skip", skip_cnt, 2'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
